// File: rtl/keypad_entry_if.sv
// Keypad entry bus: keypad strobes and sensor in, password and status out.
// Optional KEYPAD_ECHO_EN adds the key_echo accept pulse.
interface keypad_entry_if;
    logic       sensor_entrance;
    logic       key_valid;
    logic [1:0] key_code;
    logic       pass_ack;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pass_ready;
    logic       entry_busy;
    logic       timeout_err;
    logic [2:0] state_dbg;
`ifdef KEYPAD_ECHO_EN
    logic       key_echo;
`endif

    // Handshake: pass_ready stays high until a one-cycle pass_ack is seen
    // while it is high; pass_ack at any other time has no effect.
    modport master (
`ifdef KEYPAD_ECHO_EN
        input  key_echo,
`endif
        output sensor_entrance, key_valid, key_code, pass_ack,
        input  password_1, password_2, pass_ready, entry_busy, timeout_err, state_dbg
    );

    modport slave (
`ifdef KEYPAD_ECHO_EN
        output key_echo,
`endif
        input  sensor_entrance, key_valid, key_code, pass_ack,
        output password_1, password_2, pass_ready, entry_busy, timeout_err, state_dbg
    );
endinterface

// File: rtl/keypad_entry.sv
// Debounced two-digit keypad entry for the parking gate, with per-digit timeout.
// Optional KEYPAD_ECHO_EN adds key_echo, a pulse after each digit taken.
module keypad_entry #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 200
) (
    input  logic           clk,
    input  logic           reset_n,
    keypad_entry_if.slave  bus
);
    localparam int CNT_MAX = (DEBOUNCE_CYC > TIMEOUT_CYC) ? DEBOUNCE_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_D1 = 3'd1,
        S_WAIT_D2 = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t        state;
    logic          db;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] timer;
    logic [1:0]    pw1_q;
    logic [1:0]    pw2_q;
    logic          ready_q;
    logic          busy_q;
    logic          to_q;
    logic          accept;

    // db rises on this edge: last of DEBOUNCE_CYC consecutive high cycles
    assign accept = bus.key_valid && !db && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db     <= 1'b0;
            db_cnt <= '0;
        end else if (bus.key_valid == db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db     <= ~db;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef KEYPAD_ECHO_EN
    logic echo_q;
    assign bus.key_echo = echo_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            pw1_q   <= 2'b00;
            pw2_q   <= 2'b00;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
`ifdef KEYPAD_ECHO_EN
            echo_q  <= 1'b0;
`endif
        end else begin
`ifdef KEYPAD_ECHO_EN
            echo_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.sensor_entrance) begin
                        state  <= S_WAIT_D1;
                        pw1_q  <= 2'b00;
                        pw2_q  <= 2'b00;
                        timer  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_WAIT_D1, S_WAIT_D2: begin
                    // Car leaving beats accept; accept beats timeout
                    if (!bus.sensor_entrance) begin
                        state  <= S_IDLE;
                        pw1_q  <= 2'b00;
                        pw2_q  <= 2'b00;
                        timer  <= '0;
                        busy_q <= 1'b0;
                    end else if (accept) begin
                        timer <= '0;
`ifdef KEYPAD_ECHO_EN
                        echo_q <= 1'b1;
`endif
                        if (state == S_WAIT_D1) begin
                            pw1_q <= bus.key_code;
                            state <= S_WAIT_D2;
                        end else begin
                            pw2_q   <= bus.key_code;
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end else if (timer == TO_LAST) begin
                        state  <= S_TIMEOUT;
                        timer  <= '0;
                        pw1_q  <= 2'b00;
                        pw2_q  <= 2'b00;
                        busy_q <= 1'b0;
                        to_q   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!bus.sensor_entrance) begin
                        state   <= S_IDLE;
                        pw1_q   <= 2'b00;
                        pw2_q   <= 2'b00;
                        ready_q <= 1'b0;
                    end else if (bus.pass_ack) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b0;
                    end
                end
                S_TIMEOUT: begin
                    if (!bus.sensor_entrance) begin
                        state <= S_IDLE;
                        to_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    timer   <= '0;
                    pw1_q   <= 2'b00;
                    pw2_q   <= 2'b00;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    to_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.password_1  = pw1_q;
    assign bus.password_2  = pw2_q;
    assign bus.pass_ready  = ready_q;
    assign bus.entry_busy  = busy_q;
    assign bus.timeout_err = to_q;
    assign bus.state_dbg   = state;
endmodule
